// File: rtl/horner_eval.sv
// Polynomial evaluator p(x) = sum c_k*x^k using Horner's method, one MAC per clock.
// Optional overflow detection enabled by defining HORNER_OVF_EN.
module horner_eval #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEGREE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            x,
    input  logic [(DEGREE+1)*WIDTH-1:0] coef,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            result,
    output logic                        ovf
);

    localparam int unsigned K_W   = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
    localparam int unsigned NCOEF = DEGREE + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ITER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] coef_q [NCOEF];
    logic [WIDTH-1:0] coef_d [NCOEF];
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] ck;
    logic [WIDTH-1:0] mac;

    // Coefficient selected by the iteration counter
    always_comb begin
        ck = '0;
        for (int i = 0; i < int'(NCOEF); i++) begin
            if (k_q == K_W'(i)) begin
                ck = coef_q[i];
            end
        end
    end

`ifdef HORNER_OVF_EN
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH:0]     sum_full;
    logic               step_ovf;
    logic               ovf_acc_q, ovf_acc_d;
    logic               ovf_q, ovf_d;

    // Full-width MAC so carries out of the product and the add are visible
    always_comb begin
        prod_full = (2*WIDTH)'(acc_q) * (2*WIDTH)'(x_q);
        sum_full  = (WIDTH+1)'(prod_full[WIDTH-1:0]) + (WIDTH+1)'(ck);
        mac       = sum_full[WIDTH-1:0];
        step_ovf  = (|prod_full[2*WIDTH-1:WIDTH]) | sum_full[WIDTH];
    end
`else
    always_comb begin
        mac = WIDTH'(acc_q * x_q) + ck;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        x_d      = x_q;
        coef_d   = coef_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef HORNER_OVF_EN
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef HORNER_OVF_EN
                    ovf_acc_d = 1'b0;
                    ovf_d     = 1'b0;
`endif
                    if (DEGREE == 0) begin
                        result_d = coef[WIDTH-1:0];
                        done_d   = 1'b1;
                    end else begin
                        x_d = x;
                        for (int i = 0; i < int'(NCOEF); i++) begin
                            coef_d[i] = coef[i*WIDTH +: WIDTH];
                        end
                        acc_d   = coef[DEGREE*WIDTH +: WIDTH];
                        k_d     = K_W'(DEGREE - 1);
                        busy_d  = 1'b1;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                acc_d = mac;
`ifdef HORNER_OVF_EN
                ovf_acc_d = ovf_acc_q | step_ovf;
`endif
                if (k_q != '0) begin
                    k_d = k_q - K_W'(1);
                end else begin
                    result_d = mac;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
`ifdef HORNER_OVF_EN
                    ovf_d = ovf_acc_q | step_ovf;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            k_q      <= '0;
            x_q      <= '0;
            for (int i = 0; i < int'(NCOEF); i++) begin
                coef_q[i] <= '0;
            end
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

`ifdef HORNER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_horner_eval.sv
// Randomized scoreboard bench for horner_eval (DEGREE=2 main instance, DEGREE=0 side instance).
module tb_horner_eval;

    localparam int unsigned W = 16;
    localparam int unsigned D = 2;
    localparam longint unsigned M = 64'd65536;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [W-1:0]         x;
    logic [(D+1)*W-1:0]   coef;
    logic                 busy, done, ovf;
    logic [W-1:0]         result;

    logic                 start0;
    logic [W-1:0]         coef0;
    logic                 busy0, done0, ovf0;
    logic [W-1:0]         result0;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    logic [W:0] exp_q[$];
    logic [W:0] exp_e;

    always #5 clk = ~clk;

    horner_eval #(.WIDTH(W), .DEGREE(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .coef(coef),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    horner_eval #(.WIDTH(W), .DEGREE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .x(x), .coef(coef0),
        .busy(busy0), .done(done0), .result(result0), .ovf(ovf0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [(D+1)*W-1:0] pack(input logic [W-1:0] c2, input logic [W-1:0] c1,
                                                input logic [W-1:0] c0);
        return {c2, c1, c0};
    endfunction

    // Reference: power-sum for the value, step-by-step carries for the overflow flag
    function automatic logic [W:0] model(input logic [W-1:0] xv, input logic [(D+1)*W-1:0] cv);
        longint unsigned c [D+1];
        longint unsigned sum, pw, acc, p, s;
        logic ov;
        for (int k = 0; k <= int'(D); k++) c[k] = longint'(cv[k*W +: W]);
        sum = 0;
        pw  = 1;
        for (int k = 0; k <= int'(D); k++) begin
            sum = (sum + c[k] * pw) % M;
            pw  = (pw * longint'(xv)) % M;
        end
        ov  = 1'b0;
        acc = c[D];
        for (int k = int'(D) - 1; k >= 0; k--) begin
            p = acc * longint'(xv);
            if (p >= M) ov = 1'b1;
            s = (p % M) + c[k];
            if (s >= M) ov = 1'b1;
            acc = s % M;
        end
`ifndef HORNER_OVF_EN
        ov = 1'b0;
`endif
        return {ov, W'(sum)};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got result 0x%0h with no expectation", result);
            end else begin
                exp_e = exp_q.pop_front();
                check("result", 32'(result), 32'(exp_e[W-1:0]));
                check("ovf", 32'(ovf), 32'(exp_e[W]));
            end
        end
    end

    // Issue one evaluation from an idle negedge and wait for its done pulse
    task automatic run_eval(input logic [W-1:0] xv, input logic [(D+1)*W-1:0] cv,
                            input bit scramble);
        int cyc, busy_cyc;
        bit timed_out;
        cyc = 0;
        busy_cyc = 0;
        timed_out = 1'b0;
        x = xv;
        coef = cv;
        start = 1'b1;
        exp_q.push_back(model(xv, cv));
        @(negedge clk);
        start = 1'b0;
        forever begin
            cyc++;
            if (scramble) begin
                x = W'($urandom);
                coef = {W'($urandom), W'($urandom), W'($urandom)};
            end
            if (busy) busy_cyc++;
            if (done) break;
            if (cyc >= 20) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("timeout", 32'(timed_out), 32'd0);
        check("latency", 32'(cyc), 32'(D + 1));
        check("busy_cycles", 32'(busy_cyc), 32'(D));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, g;
        rst = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        x = '0;
        coef = '0;
        coef0 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_result0", 32'(result0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic evaluation: 1*4 + 2*2 + 2 = 10
        run_eval(16'd2, pack(16'd1, 16'd2, 16'd2), 1'b0);
        check("dir_result_10", 32'(result), 32'd10);

        // x=0 with inputs disturbed mid-evaluation
        run_eval(16'd0, pack(16'd7, 16'd9, 16'h1234), 1'b1);
        check("dir_result_1234", 32'(result), 32'h1234);

        // Product overflow that wraps to zero
        run_eval(16'h0100, pack(16'h0100, 16'd0, 16'd5), 1'b0);
        check("dir_result_5", 32'(result), 32'd5);
`ifdef HORNER_OVF_EN
        check("dir_ovf_set", 32'(ovf), 32'd1);
`else
        check("dir_ovf_clear", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Start held across two back-to-back evaluations
        d0 = n_done;
        x = 16'd2;
        coef = pack(16'd1, 16'd2, 16'd2);
        start = 1'b1;
        exp_q.push_back(model(x, coef));
        @(negedge clk);
        x = 16'd0;
        coef = pack(16'd7, 16'd9, 16'h1234);
        wait_idle();
        exp_q.push_back(model(x, coef));
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        check("b2b_result_hold", 32'(result), 32'd10);
        g = 0;
        while (!done && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("b2b_two_dones", 32'(n_done - d0), 32'd2);
        check("b2b_result", 32'(result), 32'h1234);

        // Reset on the second ITER edge aborts without a done pulse
        d0 = n_done;
        x = 16'd2;
        coef = pack(16'd1, 16'd2, 16'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        run_eval(16'd2, pack(16'd1, 16'd2, 16'd2), 1'b0);
        check("after_abort_10", 32'(result), 32'd10);

        // Randomized evaluations with idle gaps; small x half the time
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] xr;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xr = (i % 2 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            run_eval(xr, {W'($urandom), W'($urandom), W'($urandom)}, i % 3 == 0);
        end
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // DEGREE=0 instance: result appears the cycle after accept, never busy
        coef0 = 16'hBEEF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        coef0 = 16'h1111;
        check("d0_done", 32'(done0), 32'd1);
        check("d0_result", 32'(result0), 32'hBEEF);
        check("d0_busy", 32'(busy0), 32'd0);
        check("d0_ovf", 32'(ovf0), 32'd0);
        @(negedge clk);
        check("d0_done_pulse", 32'(done0), 32'd0);
        check("d0_result_hold", 32'(result0), 32'hBEEF);
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] cr;
            cr = W'($urandom);
            coef0 = cr;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            check("d0_rand_result", 32'(result0), 32'(cr));
            check("d0_rand_busy", 32'(busy0), 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
